// File: rtl/ov7670_emulator.sv
// OV7670 sensor stand-in: RGB444 parallel video (pclk = clk/2) from a frame-buffer.
// Define OV7670_EMU_TESTPATTERN_EN to emit 8 vertical colour bars instead.
module ov7670_emulator #(
  parameter int   c_img_cols    = 160,
  parameter int   c_img_rows    = 120,
  parameter int   c_nb_img_pxls = 15,
  parameter int   c_nb_buf      = 12,
  parameter int   c_line_pclk   = 400,
  parameter int   c_vsync_lines = 3,
  parameter int   c_vbp_lines   = 17,
  parameter int   c_vfp_lines   = 10,
  parameter logic swap_r_b      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     pclk,
  output logic                     vsync,
  output logic                     href,
  output logic [7:0]               d,
  output logic [c_nb_img_pxls-1:0] frame_addr,
  input  logic [c_nb_buf-1:0]      frame_pxl,
  output logic                     frame_done
);

  localparam int PW = $clog2(c_line_pclk);
  localparam int LW = $clog2(c_img_rows + c_vsync_lines
                             + c_vbp_lines + c_vfp_lines + 1);
  localparam int AW = c_nb_img_pxls;
  localparam logic [AW-1:0] LAST_ADDR = AW'(c_img_rows * c_img_cols - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBP    = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFP    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          pclk_q, vsync_q, href_q, done_q;
  logic [7:0]    d_q, hold_q;
  logic [AW-1:0] addr_q;
  logic [PW-1:0] pcnt_q;
  logic [LW-1:0] lcnt_q, lines_m1;
  logic          fall_w, line_end_w, last_line_w, wrap_w;
  logic          act_w, first_w;
  logic [11:0]   src_w;
  logic [3:0]    r_w, g_w, b_w;

  assign fall_w      = (state_q != S_IDLE) && pclk_q;
  assign line_end_w  = pcnt_q == PW'(c_line_pclk - 1);
  assign last_line_w = lcnt_q == lines_m1;
  assign wrap_w      = fall_w && line_end_w && last_line_w;
  assign act_w       = (state_q == S_ACTIVE)
                    && (pcnt_q < PW'(2 * c_img_cols));
  assign first_w     = act_w && !pcnt_q[0];

  // Line count of the current phase and the phase that follows it.
  always_comb begin
    lines_m1 = '0;
    state_d  = S_IDLE;
    case (state_q)
      S_IDLE: state_d = en ? S_VSYNC : S_IDLE;
      S_VSYNC: begin
        lines_m1 = LW'(c_vsync_lines - 1);
        state_d  = S_VBP;
      end
      S_VBP: begin
        lines_m1 = LW'(c_vbp_lines - 1);
        state_d  = S_ACTIVE;
      end
      S_ACTIVE: begin
        lines_m1 = LW'(c_img_rows - 1);
        state_d  = S_VFP;
      end
      S_VFP: begin
        lines_m1 = LW'(c_vfp_lines - 1);
        state_d  = en ? S_VSYNC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef OV7670_EMU_TESTPATTERN_EN
  logic [PW-1:0] bar_w;
  logic          unused_pxl;
  assign unused_pxl = ^frame_pxl;
  assign bar_w = (pcnt_q >> 1) / PW'(c_img_cols / 8);

  // Colour of the bar under the current pixel.
  always_comb begin
    case (bar_w)
      PW'(0):  src_w = 12'hFFF;
      PW'(1):  src_w = 12'hFF0;
      PW'(2):  src_w = 12'h0FF;
      PW'(3):  src_w = 12'h0F0;
      PW'(4):  src_w = 12'hF0F;
      PW'(5):  src_w = 12'hF00;
      PW'(6):  src_w = 12'h00F;
      default: src_w = 12'h000;
    endcase
  end
`else
  assign src_w = frame_pxl[11:0];
`endif

  assign r_w = swap_r_b ? src_w[3:0]  : src_w[11:8];
  assign g_w = src_w[7:4];
  assign b_w = swap_r_b ? src_w[11:8] : src_w[3:0];

  // Pixel clock, frame phase and line/pixel counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pclk_q  <= 1'b0;
      pcnt_q  <= '0;
      lcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= wrap_w && (state_q == S_VFP);
      if (state_q == S_IDLE) begin
        pclk_q  <= 1'b0;
        pcnt_q  <= '0;
        lcnt_q  <= '0;
        state_q <= state_d;
      end else begin
        pclk_q <= ~pclk_q;
        if (fall_w) begin
          if (line_end_w) begin
            pcnt_q <= '0;
            if (last_line_w) begin
              lcnt_q  <= '0;
              state_q <= state_d;
            end else begin
              lcnt_q <= lcnt_q + 1'b1;
            end
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Video outputs change only on pclk falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= 8'h00;
    end else if (fall_w) begin
      vsync_q <= state_q == S_VSYNC;
      href_q  <= act_w;
      if (!act_w)         d_q <= 8'h00;
      else if (pcnt_q[0]) d_q <= hold_q;
      else                d_q <= {4'h0, r_w};
    end
  end

  // Pixel latch and read address, prefetched one pixel ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      hold_q <= 8'h00;
    end else if ((state_q == S_IDLE) && en) begin
      addr_q <= '0;
    end else if (wrap_w && (state_q == S_VFP) && en) begin
      addr_q <= '0;
    end else if (fall_w && first_w) begin
      hold_q <= {g_w, b_w};
`ifndef OV7670_EMU_TESTPATTERN_EN
      addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
`endif
    end
  end

  assign pclk       = pclk_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign d          = d_q;
  assign frame_addr = addr_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ov7670_emulator.sv
// Directed bench for ov7670_emulator on a reduced geometry (16x6, 40 pclk/line).
// Covers both pixel sources depending on OV7670_EMU_TESTPATTERN_EN.
module tb_ov7670_emulator;

  localparam int COLS = 16;
  localparam int ROWS = 6;
  localparam int LPCLK = 40;
  localparam int VS = 2;
  localparam int VBP = 3;
  localparam int VFP = 2;
  localparam int FRAME_PCLK = (VS + VBP + ROWS + VFP) * LPCLK;
  localparam logic [14:0] LAST = 15'(ROWS * COLS - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        pclk, vsync, href, frame_done;
  logic [7:0]  d;
  logic [14:0] frame_addr;
  logic [11:0] frame_pxl = '0;
  logic        pclk_sw, vsync_sw, href_sw, done_sw;
  logic [7:0]  d_sw;
  logic [14:0] addr_sw;
  logic [11:0] pxl_sw = '0;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ov7670_emulator #(
    .c_img_cols(COLS), .c_img_rows(ROWS), .c_line_pclk(LPCLK),
    .c_vsync_lines(VS), .c_vbp_lines(VBP), .c_vfp_lines(VFP),
    .swap_r_b(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pclk(pclk), .vsync(vsync),
    .href(href), .d(d), .frame_addr(frame_addr),
    .frame_pxl(frame_pxl), .frame_done(frame_done)
  );

  ov7670_emulator #(
    .c_img_cols(COLS), .c_img_rows(ROWS), .c_line_pclk(LPCLK),
    .c_vsync_lines(VS), .c_vbp_lines(VBP), .c_vfp_lines(VFP),
    .swap_r_b(1'b1)
  ) dut_sw (
    .clk(clk), .rst(rst), .en(en), .pclk(pclk_sw), .vsync(vsync_sw),
    .href(href_sw), .d(d_sw), .frame_addr(addr_sw),
    .frame_pxl(pxl_sw), .frame_done(done_sw)
  );

  // Frame-buffer models: registered read returning the low address bits.
  always @(posedge clk) begin
    frame_pxl <= frame_addr[11:0];
    pxl_sw    <= addr_sw[11:0];
  end

  int toggles = 0, rises = 0, unstable = 0, vs_per = 0;
  int hpulses = 0, hlen = 0, hmin = 1 << 30, hmax = 0;
  int dones = 0, seq_err = 0, amax = 0, row = 0, bidx = 0;
  logic        pclk_s = 1'b0, href_s = 1'b0, h_last = 1'b0;
  logic [7:0]  d_s = '0;
  logic [14:0] addr_s = '0;
  logic [7:0]  row0 [64];
  logic [7:0]  row0s [64];

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (pclk !== pclk_s) toggles++;
    if (frame_done) dones++;
    if (frame_addr !== addr_s) begin
      if (!((frame_addr == addr_s + 15'd1) ||
            (addr_s == LAST && frame_addr == 15'd0)))
        seq_err++;
    end
    if (int'(frame_addr) > amax) amax = int'(frame_addr);
    if (pclk && !pclk_s) begin
      rises++;
      if (d !== d_s || href !== href_s) unstable++;
      if (vsync) begin
        vs_per++;
        row = 0;
      end
      if (href && !h_last) begin
        hpulses++;
        row++;
        hlen = 0;
        bidx = 0;
      end
      if (href) begin
        hlen++;
        if (row == 1 && bidx < 64) begin
          row0[bidx]  = d;
          row0s[bidx] = d_sw;
        end
        bidx++;
      end else if (h_last) begin
        if (hlen < hmin) hmin = hlen;
        if (hlen > hmax) hmax = hlen;
      end
      h_last = href;
    end
    pclk_s = pclk;
    d_s    = d;
    href_s = href;
    addr_s = frame_addr;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, b_tog, b_rise, b_vs, b_hp, b_done;

    // Reset with en low.
    #1 rst = 1'b1;
    repeat (10) tick();
    chk("rst_pclk", pclk, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_d", d, 0);
    chk("rst_addr", frame_addr, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;
    repeat (1000) tick();
    chk("idle_toggles", toggles, 0);
    chk("idle_pclk", pclk, 0);

    // Frame 1.
    b_rise = rises; b_vs = vs_per; b_hp = hpulses; b_done = dones;
    en = 1'b1;
    n = 0;
    while (dones == b_done && n < 4 * FRAME_PCLK) begin
      tick();
      n++;
    end
    chk("f1_done_seen", dones - b_done, 1);
    chk("f1_len_pclk", rises - b_rise, FRAME_PCLK);
    chk("f1_vsync_pclk", vs_per - b_vs, VS * LPCLK);
    chk("f1_href_pulses", hpulses - b_hp, ROWS);
    chk("f1_href_min", hmin, 2 * COLS);
    chk("f1_href_max", hmax, 2 * COLS);
    chk("f1_unstable", unstable, 0);
    chk("f1_addr_seq", seq_err, 0);
    chk("f1_addr_wrap", frame_addr, 0);
`ifdef OV7670_EMU_TESTPATTERN_EN
    chk("tp_addr_max", amax, 0);
    chk("tp_px0_b0", row0[0], 8'h0F);
    chk("tp_px0_b1", row0[1], 8'hFF);
    chk("tp_px2_b0", row0[4], 8'h0F);
    chk("tp_px2_b1", row0[5], 8'hF0);
    chk("tp_px14_b0", row0[28], 8'h00);
    chk("tp_px14_b1", row0[29], 8'h00);
    chk("tp_sw_px2_b0", row0s[4], 8'h00);
    chk("tp_sw_px2_b1", row0s[5], 8'hFF);
`else
    chk("addr_max", amax, int'(LAST));
    chk("px0_b0", row0[0], 8'h00);
    chk("px0_b1", row0[1], 8'h00);
    chk("px5_b0", row0[10], 8'h00);
    chk("px5_b1", row0[11], 8'h05);
    chk("px15_b1", row0[31], 8'h0F);
    chk("sw_px5_b0", row0s[10], 8'h05);
    chk("sw_px5_b1", row0s[11], 8'h00);
    chk("sw_px15_b0", row0s[30], 8'h0F);
`endif

    // Frame 2 starts straight away; drop en mid-ACTIVE.
    n = 0;
    while (!vsync && n < 100) begin
      tick();
      n++;
    end
    chk("f2_vsync_seen", vsync, 1);
    chk("f2_addr_start", frame_addr, 0);
    b_hp = hpulses; b_done = dones;
    n = 0;
    while (hpulses - b_hp < 3 && n < 4 * FRAME_PCLK) begin
      tick();
      n++;
    end
    chk("f2_line3_seen", hpulses - b_hp, 3);
    en = 1'b0;
    n = 0;
    while (dones == b_done && n < 4 * FRAME_PCLK) begin
      tick();
      n++;
    end
    chk("f2_done_seen", dones - b_done, 1);
    chk("f2_href_pulses", hpulses - b_hp, ROWS);
    chk("f2_addr_seq", seq_err, 0);
    b_tog = toggles;
    repeat (200) tick();
    chk("stop_toggles", toggles - b_tog, 0);
    chk("stop_pclk", pclk, 0);
    chk("stop_vsync", vsync, 0);
    chk("stop_done_cnt", dones - b_done, 1);

    // Reset in the middle of an active line.
    en = 1'b1;
    n = 0;
    while (!href && n < 4 * FRAME_PCLK) begin
      tick();
      n++;
    end
    chk("f3_href_seen", href, 1);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_pclk", pclk, 0);
    chk("mid_rst_vsync", vsync, 0);
    chk("mid_rst_href", href, 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_addr", frame_addr, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_sw_d", d_sw, 0);
    en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    b_tog = toggles;
    repeat (100) tick();
    chk("post_rst_toggles", toggles - b_tog, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/ov7670_emulator.md
Name: ov7670_emulator

Overview:
- Stands in for the OV7670 sensor: generates its parallel video interface (pclk, vsync, href, d[7:0]) in RGB444 mode, two bytes per pixel.
- Pixels are read from a frame-buffer read port.
- Drives ov7670_capture in simulation and on loopback boards, so capture and colour processing can be tested without a camera.
- Runs in the clk50mhz domain; pclk is generated internally as clk/2.

Parameters:
c_img_cols, 160, active pixels per line
c_img_rows, 120, active lines per frame
c_nb_img_pxls, 15, frame address width
c_nb_buf, 12, pixel word width, {R[11:8],G[7:4],B[3:0]}
c_line_pclk, 400, pclk periods per line (active + horizontal blank); must be > 2*c_img_cols
c_vsync_lines, 3, lines with vsync high
c_vbp_lines, 17, blank lines after vsync
c_vfp_lines, 10, blank lines after the last active line
swap_r_b, 1'b0, emit B in the red nibble and R in the blue nibble

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous reset, active-high
en  in  1  level; frames are generated while high
pclk  out  1  pixel clock, clk/2
vsync  out  1  frame sync, active-high
href  out  1  high during the active bytes of a line
d  out  8  pixel byte
frame_addr  out  c_nb_img_pxls  frame-buffer read address
frame_pxl  in  c_nb_buf  read data, valid 1 clk after frame_addr
frame_done  out  1  1-clk pulse at the end of the last VFP line

Behaviour:
- Reset values: pclk=0, vsync=0, href=0, d=0, frame_addr=0, frame_done=0, state IDLE, all counters 0.
- Reset is honoured mid-frame: all outputs return to reset values immediately.
- pclk toggles every clk while state != IDLE, giving a 2-clk period; it is held at 0 in IDLE.
- vsync, href and d update only in the clk cycle where pclk goes 1->0. They are therefore stable across every pclk rising edge.
- Counters advance once per pclk period, on the falling edge:
  - pcnt: 0..c_line_pclk-1.
  - lcnt: increments when pcnt wraps.
- States and transitions:
  - IDLE -> VSYNC when en=1. The first falling edge starts pcnt=0, lcnt=0.
  - VSYNC: vsync=1 for c_vsync_lines lines, then -> VBP.
  - VBP: c_vbp_lines lines with vsync=0 and href=0, then -> ACTIVE.
  - ACTIVE: c_img_rows lines, then -> VFP.
  - VFP: c_vfp_lines lines. At its last pclk, frame_done pulses. Next state is VSYNC if en=1, otherwise IDLE (pclk stops at 0).
- en is sampled only at the end of a frame. Dropping en mid-frame completes the current frame.
- ACTIVE line:
  - href=1 for pcnt 0..2*c_img_cols-1, then 0 for the rest of the line.
  - Byte 2k carries pixel k's first byte, {4'b0000, R}.
  - Byte 2k+1 carries {G, B}.
  - With swap_r_b=1, R and B exchange places.
  - d=0 whenever href=0.
- Memory read:
  - frame_addr for pixel k is presented at least 2 clk before the falling edge that drives byte 2k.
  - frame_pxl is registered into a pixel latch at that falling edge; byte 2k+1 uses the latch.
- Address sequence:
  - frame_addr increments once per pixel, row-major.
  - It wraps to 0 after c_img_rows*c_img_cols-1 = 19199.
  - It is reset to 0 at entry to VSYNC.
  - It never exceeds 19199; the next value is prefetched as 0 during blanking.
- Frame length: (c_vsync_lines + c_vbp_lines + c_img_rows + c_vfp_lines) * c_line_pclk pclk periods. Defaults: 150*400 = 60000 pclk = 120000 clk.

Optional Feature:
- Macro: OV7670_EMU_TESTPATTERN_EN.
- When defined:
  - frame_pxl is ignored and frame_addr is held at 0.
  - Pixels come from internal 8 vertical colour bars, each c_img_cols/8 wide.
  - Bar order: white 12'hFFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - swap_r_b still applies.
- When undefined: pixels come from frame_pxl as described above.

Test Plan:
- Reset held 10 clk, en=0 -> pclk, vsync, href and d all 0; frame_addr=0; no pclk toggles for 1000 clk.
- en=1, count one frame -> vsync high for exactly 1200 pclk; exactly 120 href pulses, each 320 pclk long; frame_done pulses once after 60000 pclk.
- Memory model returns frame_pxl = addr[11:0]; check pixel 5 of row 0 -> bytes 8'h00, 8'h05; with swap_r_b=1 -> 8'h05, 8'h00.
- Check d and href against every pclk rising edge -> no transitions in the clk where pclk rises; frame_addr runs 0..19199, then reads 0 again at the second frame.
- en dropped at line 50 -> frame completes (120 href pulses), frame_done pulses, pclk stays 0; rst asserted mid-ACTIVE -> all outputs 0 immediately.
- With OV7670_EMU_TESTPATTERN_EN, capture row 0 -> pixels 0..19 = FFF, pixels 140..159 = 000, pixel 20 = FF0.
